// File: rtl/biriscv_fetch_queue_if.sv
// Fetch-queue bus: fetch-side packet push, decoder-side lane pops, flush and occupancy.
// The queue instance uses the slave modport; the fetch/decode side uses master.
interface biriscv_fetch_queue_if #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned INFO_W = 2
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic                    flush_i;
    logic                    push_i;
    logic                    accept_o;
    logic [31:0]             pc_in_i;
    logic [LANES-1:0]        pred_in_i;
    logic [32*LANES-1:0]     data_in_i;
    logic [INFO_W*LANES-1:0] info_in_i;
    logic [LANES-1:0]        valid_o;
    logic [32*LANES-1:0]     pc_o;
    logic [32*LANES-1:0]     data_o;
    logic [INFO_W*LANES-1:0] info_o;
    logic [LANES-1:0]        pop_i;
    logic [LW-1:0]           level_o;

    modport master (
        output flush_i, push_i, pc_in_i, pred_in_i, data_in_i, info_in_i, pop_i,
        input  accept_o, valid_o, pc_o, data_o, info_o, level_o
    );

    modport slave (
        input  flush_i, push_i, pc_in_i, pred_in_i, data_in_i, info_in_i, pop_i,
        output accept_o, valid_o, pc_o, data_o, info_o, level_o
    );
endinterface

// File: rtl/biriscv_fetch_queue.sv
// Fetch-packet queue: DEPTH slots of LANES instructions, lanes retire independently.
// Optional feature: define BIRISCV_FETCH_QUEUE_BYPASS_EN to present an incoming
// packet at the head of an empty queue in the same cycle.
module biriscv_fetch_queue #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned INFO_W = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    biriscv_fetch_queue_if.slave q
);
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned LW   = PW + 1;
    localparam int unsigned DW   = 32 * LANES;
    localparam int unsigned IW   = INFO_W * LANES;
    localparam int unsigned PKTB = 4 * LANES;

    logic [31:0]      pc_q   [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [IW-1:0]    info_q [DEPTH];
    logic [LANES-1:0] mask_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [LW-1:0]    count_q;

    logic             empty;
    logic             full;
    logic             bypass;
    logic             retire;
    logic             do_write;
    logic [LANES-1:0] push_mask;
    logic [LANES-1:0] head_mask;
    logic [LANES-1:0] valid_c;
    logic [LANES-1:0] pop_w;
    logic [LANES-1:0] wr_mask;
    logic [31:0]      head_pc;
    logic [31:0]      start_lane;
    logic             blocked;

    assign empty     = (count_q == LW'(0));
    assign full      = (count_q == LW'(DEPTH));
    assign head_mask = mask_q[rd_ptr_q];

`ifdef BIRISCV_FETCH_QUEUE_BYPASS_EN
    assign bypass = empty && q.push_i && !q.flush_i;
`else
    assign bypass = 1'b0;
`endif

    // Lanes from the start lane up to and including the first predicted-taken lane
    always_comb begin
        push_mask  = '0;
        blocked    = 1'b0;
        start_lane = (q.pc_in_i >> 2) & 32'(LANES - 1);
        for (int k = 0; k < LANES; k++) begin
            if (32'(k) >= start_lane && !blocked) begin
                push_mask[k] = 1'b1;
                if (q.pred_in_i[k]) begin
                    blocked = 1'b1;
                end
            end
        end
    end

    // Head selection: stored head packet, or the incoming packet when bypassing
    always_comb begin
        valid_c = '0;
        head_pc = pc_q[rd_ptr_q];
        q.data_o = data_q[rd_ptr_q];
        q.info_o = info_q[rd_ptr_q];
        if (bypass) begin
            valid_c  = push_mask;
            head_pc  = q.pc_in_i;
            q.data_o = q.data_in_i;
            q.info_o = q.info_in_i;
        end else if (!empty) begin
            valid_c = head_mask;
        end
        for (int k = 0; k < LANES; k++) begin
            q.pc_o[32*k +: 32] = (head_pc & ~32'(PKTB - 1)) | 32'(4 * k);
        end
    end

    assign q.valid_o  = valid_c;
    assign q.accept_o = !full;
    assign q.level_o  = count_q;

    assign pop_w    = q.pop_i & valid_c;
    assign retire   = !empty && ((head_mask & ~pop_w) == '0);
    assign wr_mask  = bypass ? (push_mask & ~pop_w) : push_mask;
    assign do_write = q.push_i && !full && (wr_mask != '0);

    // Slot storage, pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
                info_q[i] <= '0;
                mask_q[i] <= '0;
            end
        end else if (q.flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mask_q[i] <= '0;
            end
        end else begin
            if (!empty) begin
                mask_q[rd_ptr_q] <= head_mask & ~pop_w;
            end
            if (retire) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (do_write) begin
                pc_q[wr_ptr_q]   <= q.pc_in_i;
                data_q[wr_ptr_q] <= q.data_in_i;
                info_q[wr_ptr_q] <= q.info_in_i;
                mask_q[wr_ptr_q] <= wr_mask;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (do_write && !retire) begin
                count_q <= count_q + LW'(1);
            end else if (retire && !do_write) begin
                count_q <= count_q - LW'(1);
            end
        end
    end
endmodule

// File: tb/tb_biriscv_fetch_queue.sv
// Randomized and directed bench for biriscv_fetch_queue against a packet-queue model.
module tb_biriscv_fetch_queue;
    localparam int unsigned LANES  = 2;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned INFO_W = 2;

    typedef struct {
        logic [31:0] pc;
        logic [63:0] data;
        logic [3:0]  info;
        logic [1:0]  mask;
    } pkt_t;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    int   errs   = 0;
    int   checks = 0;
    pkt_t mq[$];

    always #5 clk = ~clk;

    biriscv_fetch_queue_if #(.LANES(LANES), .DEPTH(DEPTH), .INFO_W(INFO_W)) bus ();

    biriscv_fetch_queue #(.LANES(LANES), .DEPTH(DEPTH), .INFO_W(INFO_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .q      (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Lanes s..first-taken-at-or-above-s, built as a contiguous bit range
    function automatic logic [1:0] ref_mask(input logic [31:0] pc, input logic [1:0] pred);
        int s;
        int e;
        s = int'((pc >> 2) % LANES);
        e = LANES - 1;
        for (int j = LANES - 1; j >= s; j--) begin
            if (pred[j]) e = j;
        end
        return 2'(((1 << (e + 1)) - 1) & ~((1 << s) - 1));
    endfunction

    task automatic set_idle();
        bus.flush_i   = 1'b0;
        bus.push_i    = 1'b0;
        bus.pop_i     = '0;
        bus.pc_in_i   = '0;
        bus.pred_in_i = '0;
        bus.data_in_i = '0;
        bus.info_in_i = '0;
    endtask

    // Drive one cycle, check outputs mid-cycle against the model, then advance the model
    task automatic cycle(input logic fl, input logic ps, input logic [31:0] pc,
                         input logic [1:0] pred, input logic [63:0] d,
                         input logic [3:0] inf, input logic [1:0] pp);
        int          n;
        logic        byp;
        logic        acc;
        logic [1:0]  ev;
        logic [1:0]  popped;
        logic [1:0]  m;
        logic [31:0] epc;
        logic [63:0] ed;
        logic [3:0]  ei;
        bus.flush_i   = fl;
        bus.push_i    = ps;
        bus.pc_in_i   = pc;
        bus.pred_in_i = pred;
        bus.data_in_i = d;
        bus.info_in_i = inf;
        bus.pop_i     = pp;
        @(negedge clk);
        n   = mq.size();
        byp = 1'b0;
`ifdef BIRISCV_FETCH_QUEUE_BYPASS_EN
        byp = (n == 0) && ps && !fl;
`endif
        ev = 2'b00; epc = '0; ed = '0; ei = '0;
        if (byp) begin
            ev = ref_mask(pc, pred); epc = pc; ed = d; ei = inf;
        end else if (n > 0) begin
            ev = mq[0].mask; epc = mq[0].pc; ed = mq[0].data; ei = mq[0].info;
        end
        acc = (n < DEPTH);
        chk("accept", 64'(bus.accept_o), 64'(acc));
        chk("valid", 64'(bus.valid_o), 64'(ev));
        chk("level", 64'(bus.level_o), 64'(n));
        if (ev != 2'b00) begin
            chk("pc", bus.pc_o, {(epc & ~32'h7) | 32'h4, epc & ~32'h7});
            chk("data", bus.data_o, ed);
            chk("info", 64'(bus.info_o), 64'(ei));
        end
        if (fl) begin
            mq.delete();
        end else begin
            popped = pp & ev;
            if (byp) begin
                m = ev & ~popped;
                if (m != 2'b00) mq.push_back('{pc, d, inf, m});
            end else begin
                if (n > 0) begin
                    mq[0].mask = mq[0].mask & ~popped;
                    if (mq[0].mask == 2'b00) void'(mq.pop_front());
                end
                if (ps && acc) mq.push_back('{pc, d, inf, ref_mask(pc, pred)});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, '0, '0, '0, '0, '0);
    endtask

    initial begin
        set_idle();
        rst_ni = 1'b0;
        @(negedge clk);
        chk("rst_accept", 64'(bus.accept_o), 64'd1);
        chk("rst_valid", 64'(bus.valid_o), 64'd0);
        chk("rst_level", 64'(bus.level_o), 64'd0);
        chk("rst_data", bus.data_o, 64'd0);
        chk("rst_info", 64'(bus.info_o), 64'd0);
        chk("rst_pc", bus.pc_o, 64'h0000_0004_0000_0000);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Full packet from lane 0
        cycle(1'b0, 1'b1, 32'h100, 2'b00, {32'hBBBB_BBBB, 32'hAAAA_AAAA}, 4'h9, 2'b00);
        set_idle();
        #1;
        chk("tp_valid11", 64'(bus.valid_o), 64'd3);
        chk("tp_pc", bus.pc_o, {32'h104, 32'h100});
        chk("tp_level1", 64'(bus.level_o), 64'd1);
        cycle(1'b0, 1'b0, '0, '0, '0, '0, 2'b11);

        // Mid-packet start lane, then a taken prediction in lane 0
        cycle(1'b0, 1'b1, 32'h104, 2'b00, 64'h1111_2222_3333_4444, 4'h3, 2'b00);
        set_idle();
        #1;
        chk("tp_valid10", 64'(bus.valid_o), 64'd2);
        cycle(1'b0, 1'b1, 32'h100, 2'b01, 64'h5555_6666_7777_8888, 4'h6, 2'b10);
        set_idle();
        #1;
        chk("tp_valid01", 64'(bus.valid_o), 64'd1);
        cycle(1'b0, 1'b0, '0, '0, '0, '0, 2'b01);

        // Fill past capacity, then flush with a simultaneous push
        for (int i = 0; i < DEPTH + 1; i++) begin
            cycle(1'b0, 1'b1, 32'h200 + 32'(8 * i), 2'b00, 64'(i + 1), 4'(i), 2'b00);
        end
        set_idle();
        #1;
        chk("full_accept", 64'(bus.accept_o), 64'd0);
        chk("full_level", 64'(bus.level_o), 64'(DEPTH));
        cycle(1'b1, 1'b1, 32'h300, 2'b00, 64'hDEAD, 4'h1, 2'b00);
        set_idle();
        #1;
        chk("flush_valid", 64'(bus.valid_o), 64'd0);
        chk("flush_level", 64'(bus.level_o), 64'd0);

        // Wrap: push each cycle while popping the whole head
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 32'h400 + 32'(8 * i), 2'b00, 64'(32'hC0 + i), 4'(i), 2'b11);
            chk("wrap_level_bound", 64'(bus.level_o <= 3'(DEPTH)), 64'd1);
        end
        cycle(1'b0, 1'b0, '0, '0, '0, '0, 2'b11);

`ifdef BIRISCV_FETCH_QUEUE_BYPASS_EN
        cycle(1'b0, 1'b1, 32'h500, 2'b00, 64'hABCD, 4'h2, 2'b11);
        set_idle();
        #1;
        chk("byp_level0", 64'(bus.level_o), 64'd0);
        cycle(1'b0, 1'b1, 32'h508, 2'b00, 64'hBCDE, 4'h4, 2'b01);
        set_idle();
        #1;
        chk("byp_valid10", 64'(bus.valid_o), 64'd2);
        cycle(1'b0, 1'b0, '0, '0, '0, '0, 2'b10);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 6),
                  32'($urandom) & ~32'h3, 2'($urandom), {32'($urandom), 32'($urandom)},
                  4'($urandom), 2'($urandom));
            chk("rnd_level_bound", 64'(bus.level_o <= 3'(DEPTH)), 64'd1);
        end

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 32'h600 + 32'(8 * i), 2'b00, 64'(i + 7), 4'(i), 2'b00);
        end
        set_idle();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_level", 64'(bus.level_o), 64'd0);
        chk("arst_valid", 64'(bus.valid_o), 64'd0);
        chk("arst_accept", 64'(bus.accept_o), 64'd1);
        mq.delete();
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        idle_cycle();
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
